// File: rtl/mux2_rr_sel_arbiter_if.sv
// rtl/mux2_rr_sel_arbiter_if.sv - request/mux-control bundle for mux2_rr_sel_arbiter
// Optional lock signal present when MUX2_RR_LOCK_EN is defined.
interface mux2_rr_sel_arbiter_if;
  logic [3:0] req;
  logic       e;
  logic [1:0] s;
  logic [3:0] gnt;
  logic       busy;
`ifdef MUX2_RR_LOCK_EN
  logic       lock;
`endif

`ifdef MUX2_RR_LOCK_EN
  modport slave  (input  req, lock, output e, s, gnt, busy);
  modport master (output req, lock, input  e, s, gnt, busy);
`else
  modport slave  (input  req, output e, s, gnt, busy);
  modport master (output req, input  e, s, gnt, busy);
`endif
endinterface

// File: rtl/mux2_rr_sel_arbiter.sv
// rtl/mux2_rr_sel_arbiter.sv - round-robin arbiter driving e/s of a 2-bit 4-to-1 mux
// Break-before-make gap between grants; MUX2_RR_LOCK_EN adds a lock input that extends a grant.
module mux2_rr_sel_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux2_rr_sel_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_CYCLES);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_s, w_s_nxt;
  logic [1:0]       r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_e, w_e_nxt;
  logic [3:0]       r_gnt, w_gnt_nxt;
  logic             r_busy, w_busy_nxt;

  logic             w_any;
  logic [1:0]       w_win;
  logic             w_lock;
  logic             w_release;

`ifdef MUX2_RR_LOCK_EN
  assign w_lock = bus.lock;
`else
  assign w_lock = 1'b0;
`endif

  assign w_any = |bus.req;

  // Scan from farthest to nearest so the channel closest after r_ptr wins.
  always_comb begin
    w_win = r_ptr;
    for (int k = 4; k >= 1; k--) begin
      if (bus.req[r_ptr + 2'(k)]) begin
        w_win = r_ptr + 2'(k);
      end
    end
  end

  // Lock only suppresses the dwell limit; a dropped request still releases.
  assign w_release = !bus.req[r_s] || ((r_cnt >= HOLD) && !w_lock);

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_e_nxt     = 1'b0;
    w_gnt_nxt   = 4'b0000;
    w_busy_nxt  = 1'b0;
    case (r_state)
      ST_IDLE, ST_GAP: begin
        if (w_any) begin
          w_state_nxt = ST_GRANT;
          w_s_nxt     = w_win;
          w_ptr_nxt   = w_win;
          w_cnt_nxt   = CNT_W'(1);
          w_e_nxt     = 1'b1;
          w_gnt_nxt   = 4'b0001 << w_win;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      ST_GRANT: begin
        w_busy_nxt = 1'b1;
        if (w_release) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_e_nxt   = 1'b1;
          w_gnt_nxt = r_gnt;
          w_cnt_nxt = (r_cnt >= HOLD) ? HOLD : r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_s     <= 2'b00;
      r_ptr   <= 2'd3;
      r_cnt   <= '0;
      r_e     <= 1'b0;
      r_gnt   <= 4'b0000;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_e     <= w_e_nxt;
      r_gnt   <= w_gnt_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign bus.e    = r_e;
  assign bus.s    = r_s;
  assign bus.gnt  = r_gnt;
  assign bus.busy = r_busy;

endmodule

// File: tb/tb_mux2_rr_sel_arbiter.sv
// tb/tb_mux2_rr_sel_arbiter.sv - bench for mux2_rr_sel_arbiter (HOLD 4 and HOLD 1 instances)
// Lock sequence included when MUX2_RR_LOCK_EN is defined.
module tb_mux2_rr_sel_arbiter;

  logic       clk = 1'b0;
  logic       r_rst_n = 1'b0;
  logic [3:0] r_req = 4'b0000;
  logic       r_lock = 1'b0;

  int n_pass = 0;
  int n_tot  = 0;

  mux2_rr_sel_arbiter_if ifc0 ();
  mux2_rr_sel_arbiter_if ifc1 ();

  assign ifc0.req = r_req;
  assign ifc1.req = r_req;
`ifdef MUX2_RR_LOCK_EN
  assign ifc0.lock = r_lock;
  assign ifc1.lock = r_lock;
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  mux2_rr_sel_arbiter #(.HOLD_CYCLES(4), .CNT_W(3)) dut0 (.clk(clk), .rst_n(r_rst_n), .bus(ifc0));
  mux2_rr_sel_arbiter #(.HOLD_CYCLES(1), .CNT_W(3)) dut1 (.clk(clk), .rst_n(r_rst_n), .bus(ifc1));

  always #5 clk = ~clk;

  // Reference model: phase 0=idle 1=granting 2=gap, one entry per instance.
  int m_hold [2] = '{4, 1};
  int m_phase[2] = '{0, 0};
  int m_sel  [2] = '{0, 0};
  int m_last [2] = '{3, 3};
  int m_dwell[2] = '{0, 0};

  function automatic int pick(int last, logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!r_rst_n) begin
        m_phase[i] = 0; m_sel[i] = 0; m_last[i] = 3; m_dwell[i] = 0;
      end else if (m_phase[i] == 1) begin
        bit locked;
        locked = LOCK_EN && r_lock && r_req[m_sel[i]];
        if (!r_req[m_sel[i]] || (m_dwell[i] >= m_hold[i] && !locked)) begin
          m_phase[i] = 2;
        end else begin
          m_dwell[i] = (m_dwell[i] + 1 > m_hold[i]) ? m_hold[i] : m_dwell[i] + 1;
        end
      end else begin
        int w;
        w = pick(m_last[i], r_req);
        if (w >= 0) begin
          m_phase[i] = 1; m_sel[i] = w; m_last[i] = w; m_dwell[i] = 1;
        end else begin
          m_phase[i] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(string nm, int act, int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic chk_out(string nm, int inst, bit e, int s, int g, bit b);
    if (inst == 0) begin
      chk({nm, ".e"}, ifc0.e, e);     chk({nm, ".s"}, ifc0.s, s);
      chk({nm, ".gnt"}, ifc0.gnt, g); chk({nm, ".busy"}, ifc0.busy, b);
    end else begin
      chk({nm, ".e"}, ifc1.e, e);     chk({nm, ".s"}, ifc1.s, s);
      chk({nm, ".gnt"}, ifc1.gnt, g); chk({nm, ".busy"}, ifc1.busy, b);
    end
  endtask

  typedef struct {
    bit         rst_n;
    logic [3:0] req;
    bit         lock;
    bit         e;
    int         s;
    int         g;
    bit         b;
    string      nm;
  } vec_t;

  vec_t vq[$];

  function automatic void add(bit rn, logic [3:0] rq, bit e, int s, int g, bit b, string nm);
    vec_t v;
    v.rst_n = rn; v.req = rq; v.lock = 1'b0; v.e = e; v.s = s; v.g = g; v.b = b; v.nm = nm;
    vq.push_back(v);
  endfunction

  initial begin
    // reset with all requests, then fairness 0,1,2,3,0 with 4-cycle dwell and one gap
    add(0, 4'hF, 0, 0, 0, 0, "rst_a");
    add(0, 4'hF, 0, 0, 0, 0, "rst_b");
    for (int n = 0; n < 5; n++) begin
      for (int d = 0; d < 4; d++) add(1, 4'hF, 1, n % 4, 1 << (n % 4), 1, "fair_grant");
      add(1, 4'hF, 0, n % 4, 0, 1, "fair_gap");
    end
    // single requester on channel 2 is re-granted after each gap
    add(0, 4'h4, 0, 0, 0, 0, "single_rst");
    for (int n = 0; n < 2; n++) begin
      for (int d = 0; d < 4; d++) add(1, 4'h4, 1, 2, 4, 1, "single_grant");
      add(1, 4'h4, 0, 2, 0, 1, "single_gap");
    end
    // early release on channel 1, then next winner is 3
    add(0, 4'h2, 0, 0, 0, 0, "early_rst");
    add(1, 4'h2, 1, 1, 2, 1, "early_g1");
    add(1, 4'h2, 1, 1, 2, 1, "early_g2");
    add(1, 4'h9, 0, 1, 0, 1, "early_gap");
    add(1, 4'h9, 1, 3, 8, 1, "early_next");
    add(1, 4'h9, 1, 3, 8, 1, "early_next2");
    add(1, 4'h0, 0, 3, 0, 1, "drop_gap");
    add(1, 4'h0, 0, 3, 0, 0, "drop_idle");
    // reset mid-grant on channel 2 restores pointer
    add(0, 4'h4, 0, 0, 0, 0, "midrst_rst");
    add(1, 4'h4, 1, 2, 4, 1, "midrst_g2");
    add(0, 4'h4, 0, 0, 0, 0, "midrst_hit");
    add(1, 4'h6, 1, 1, 2, 1, "midrst_after");
    // request drops on the same cycle dwell limit is reached: one gap
    add(0, 4'h1, 0, 0, 0, 0, "coinc_rst");
    for (int d = 0; d < 4; d++) add(1, 4'h1, 1, 0, 1, 1, "coinc_grant");
    add(1, 4'h0, 0, 0, 0, 1, "coinc_gap");
    add(1, 4'h0, 0, 0, 0, 0, "coinc_idle");

    foreach (vq[i]) begin
      r_rst_n = vq[i].rst_n; r_req = vq[i].req; r_lock = vq[i].lock;
      tick();
      chk_out(vq[i].nm, 0, vq[i].e, vq[i].s, vq[i].g, vq[i].b);
    end

    // HOLD_CYCLES=1: one-cycle grants alternating with gaps
    r_rst_n = 0; r_req = 4'h1; tick();
    chk_out("h1_rst", 1, 0, 0, 0, 0);
    r_rst_n = 1;
    for (int n = 0; n < 3; n++) begin
      tick(); chk_out("h1_grant", 1, 1, 0, 1, 1);
      tick(); chk_out("h1_gap", 1, 0, 0, 0, 1);
    end

`ifdef MUX2_RR_LOCK_EN
    r_rst_n = 0; r_req = 4'h1; r_lock = 1; tick();
    r_rst_n = 1;
    for (int n = 0; n < 10; n++) begin
      tick(); chk_out("lock_hold", 0, 1, 0, 1, 1);
    end
    r_lock = 0;
    tick(); chk_out("lock_drop_gap", 0, 0, 0, 0, 1);
    tick(); chk_out("lock_regrant", 0, 1, 0, 1, 1);
`endif

    // randomized stimulus against the model, both instances
    r_rst_n = 1; r_lock = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) < 3) r_req = 4'($urandom_range(0, 15));
      r_rst_n = ($urandom_range(0, 63) != 0);
      r_lock = ($urandom_range(0, 3) == 0);
      tick();
      for (int i = 0; i < 2; i++) begin
        bit me;
        me = (m_phase[i] == 1);
        chk_out(i == 0 ? "rand_h4" : "rand_h1", i, me, m_sel[i],
                me ? (1 << m_sel[i]) : 0, m_phase[i] != 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
